key_note_ctrl: RTL and testbench
================================

KEY_NOTE_CTRL -- requirements
Module: key_note_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd1_000_000, the number of consecutive cycles a raw input must disagree with its debounced value before that value updates (minimum 1).
REQ-002 SHALL have parameter SUSTAIN_CYCLES, default 25'd10_000_000, the number of ring cycles held after the last key release (0 allowed).
REQ-003 SHALL have port iClk, input, 1 bit, the single clock at 100 MHz; all logic is on its rising edge.
REQ-004 SHALL have port iReset, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 SHALL have port iKey, input, 8 bits, raw asynchronous piano keys; bit0=C4 through bit7=C5.
REQ-006 SHALL have port iOctUp, input, 1 bit, raw octave-up button.
REQ-007 SHALL have port iOctDn, input, 1 bit, raw octave-down button.
REQ-008 SHALL have port oRing, output, 1 bit, ring enable for the downstream note player.
REQ-009 SHALL have port oFreq, output, 21 bits, half-period in clocks; the downstream player toggles every oFreq cycles.
REQ-010 SHALL have port oNoteIdx, output, 3 bits, index of the currently selected key.
REQ-011 SHALL have port oOctave, output, 2 bits, two's-complement octave offset in the range -1..+1.

Function
REQ-012 SHALL pass each of the 10 raw inputs through a 2-flop synchronizer and then an independent debouncer.
REQ-013 Each debouncer SHALL count cycles in which the synchronized input differs from its debounced value, clear that count on any cycle where they match, and flip the debounced value on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-014 SHALL select the lowest-index asserted debounced key as the active key; no debounced key asserted means no active key.
REQ-015 SHALL use the base half-period table for keys 0..7: 191113, 170262, 151686, 143173, 127551, 113636, 101239, 95557.
REQ-016 SHALL compute oFreq from the table by octave: 0 gives the table value, +1 gives the table value shifted right 1 (floor), -1 gives the table value shifted left 1 (max 382226, no overflow in 21 bits).
REQ-017 SHALL update the octave register on a debounced rising edge of OctUp (+1) or OctDn (-1), saturating at +1 and -1; simultaneous rising edges in the same cycle SHALL leave it unchanged.
REQ-018 SHALL implement the state machine IDLE, PLAY, SUSTAIN.
REQ-019 From IDLE, an active key SHALL cause a transition to PLAY.
REQ-020 From PLAY, having no active key SHALL cause a transition to SUSTAIN, or directly to IDLE if SUSTAIN_CYCLES=0.
REQ-021 In SUSTAIN, an active key SHALL cause a transition to PLAY and clear the sustain counter.
REQ-022 In SUSTAIN, once the counter reaches SUSTAIN_CYCLES, the block SHALL transition to IDLE.
REQ-023 oRing SHALL be 1 in PLAY and SUSTAIN and 0 in IDLE, registered so that it is valid the cycle after the state is entered.
REQ-024 In PLAY, oFreq and oNoteIdx SHALL follow the active key, updating one cycle after the active key changes, including a higher-priority key pressed over a held one or a release that exposes a lower-priority held key.
REQ-025 In SUSTAIN and IDLE, oNoteIdx SHALL hold the last key played.
REQ-026 oFreq SHALL always reflect the current octave applied to oNoteIdx, updating one cycle after an octave change in any state.
REQ-027 Latency SHALL be: raw key edge to oRing/oFreq change = 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycle.

Reset
REQ-028 While iReset=1 at a clock edge, the block SHALL force state=IDLE, oRing=0, oFreq=0, oNoteIdx=0, oOctave=0, all debounced values=0, and all counters=0.
REQ-029 Reset asserted mid-PLAY or mid-SUSTAIN SHALL drop oRing to 0 on the same edge; held keys SHALL be re-debounced from 0 after reset release.
REQ-030 Button or key pulses shorter than DEBOUNCE_CYCLES SHALL produce no output change.

Verification (DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10)
REQ-031 Hold iKey=8'h01 -> oRing=1, oFreq=191113, oNoteIdx=0, exactly 7 cycles after the raw edge.
REQ-032 Hold 8'h20, then add 8'h04 (iKey=8'h24) -> oFreq 113636 then 151686; release bit2 -> oFreq returns to 113636; oRing stays 1 throughout.
REQ-033 Release all keys -> oRing stays 1 for 10 cycles of SUSTAIN then 0; re-pressing a key at sustain cycle 5 -> PLAY, oRing never drops.
REQ-034 With key0 held, press iOctUp 3 times -> oFreq 95556, then saturates at 95556, oOctave=+1; press iOctDn twice -> oFreq 382226, oOctave=-1.
REQ-035 A 3-cycle glitch on iKey[7] or iOctUp -> no change on any output; both octave buttons pressed together -> oOctave unchanged.
REQ-036 Assert iReset for 1 cycle during SUSTAIN -> all outputs reset next edge; a key still held -> replay after 7 cycles.

Source files
------------

// File: rtl/key_note_ctrl.sv
// Piano key/octave front end: sync + debounce ten buttons, pick the lowest held key, drive ring/half-period.
// Latency raw edge -> outputs is 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure, outputs are level-valued.
module key_note_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [24:0] SUSTAIN_CYCLES  = 25'd10_000_000
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [7:0]  iKey,
  input  logic        iOctUp,
  input  logic        iOctDn,
  output logic        oRing,
  output logic [20:0] oFreq,
  output logic [2:0]  oNoteIdx,
  output logic [1:0]  oOctave
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } state_e;

  localparam logic [1:0] OCT_UP = 2'b01;
  localparam logic [1:0] OCT_DN = 2'b11;

  // bits 7:0 keys, bit 8 octave up, bit 9 octave down
  logic [9:0]       raw;
  logic [9:0]       sync1_q, sync1_d;
  logic [9:0]       sync2_q, sync2_d;
  logic [9:0]       deb_q, deb_d;
  logic [9:0][19:0] cnt_q, cnt_d;
  logic [1:0]       btn_prev_q, btn_prev_d;
  logic [1:0]       octave_q, octave_d;
  state_e           state_q, state_d;
  logic [24:0]      sus_cnt_q, sus_cnt_d;
  logic             ring_q, ring_d;
  logic [2:0]       note_q, note_d;
  logic [20:0]      freq_q, freq_d;
  logic             key_any;
  logic [2:0]       key_idx;
  logic             up_rise, dn_rise;

  assign raw = {iOctDn, iOctUp, iKey};

  function automatic logic [20:0] half_period(input logic [2:0] idx, input logic [1:0] oct);
    logic [20:0] base;
    case (idx)
      3'd0:    base = 21'd191113;
      3'd1:    base = 21'd170262;
      3'd2:    base = 21'd151686;
      3'd3:    base = 21'd143173;
      3'd4:    base = 21'd127551;
      3'd5:    base = 21'd113636;
      3'd6:    base = 21'd101239;
      default: base = 21'd95557;
    endcase
    case (oct)
      OCT_UP:  return base >> 1;
      OCT_DN:  return base << 1;
      default: return base;
    endcase
  endfunction

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 10; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] + 20'd1 == DEBOUNCE_CYCLES) begin
        cnt_d[i] = '0;
        deb_d[i] = ~deb_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
  end

  // Simultaneous up and down presses cancel out.
  always_comb begin
    btn_prev_d = deb_q[9:8];
    up_rise    = deb_q[8] & ~btn_prev_q[0];
    dn_rise    = deb_q[9] & ~btn_prev_q[1];
    octave_d   = octave_q;
    if (up_rise && !dn_rise && octave_q != OCT_UP) begin
      octave_d = octave_q + 2'd1;
    end else if (dn_rise && !up_rise && octave_q != OCT_DN) begin
      octave_d = octave_q - 2'd1;
    end
  end

  always_comb begin
    key_any = |deb_q[7:0];
    key_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (deb_q[i]) key_idx = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    sus_cnt_d = sus_cnt_q;
    case (state_q)
      IDLE: begin
        if (key_any) state_d = PLAY;
      end
      PLAY: begin
        if (!key_any) begin
          sus_cnt_d = '0;
          state_d   = (SUSTAIN_CYCLES == 25'd0) ? IDLE : SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (key_any) begin
          state_d   = PLAY;
          sus_cnt_d = '0;
        end else if (sus_cnt_q + 25'd1 == SUSTAIN_CYCLES) begin
          state_d   = IDLE;
          sus_cnt_d = '0;
        end else begin
          sus_cnt_d = sus_cnt_q + 25'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        sus_cnt_d = '0;
      end
    endcase
    ring_d = (state_d != IDLE);
    note_d = key_any ? key_idx : note_q;
    freq_d = half_period(note_d, octave_d);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      btn_prev_q <= '0;
      octave_q   <= '0;
      state_q    <= IDLE;
      sus_cnt_q  <= '0;
      ring_q     <= 1'b0;
      note_q     <= '0;
      freq_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      octave_q   <= octave_d;
      state_q    <= state_d;
      sus_cnt_q  <= sus_cnt_d;
      ring_q     <= ring_d;
      note_q     <= note_d;
      freq_q     <= freq_d;
    end
  end

  assign oRing    = ring_q;
  assign oFreq    = freq_q;
  assign oNoteIdx = note_q;
  assign oOctave  = octave_q;

endmodule

// File: tb/tb_key_note_ctrl.sv
// Directed bench for key_note_ctrl with DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10.
module tb_key_note_ctrl;

  logic        iClk;
  logic        iReset;
  logic [7:0]  iKey;
  logic        iOctUp;
  logic        iOctDn;
  logic        oRing;
  logic [20:0] oFreq;
  logic [2:0]  oNoteIdx;
  logic [1:0]  oOctave;

  int n_checks = 0;
  int n_fail   = 0;

  key_note_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .SUSTAIN_CYCLES (25'd10)
  ) dut (
    .iClk    (iClk),
    .iReset  (iReset),
    .iKey    (iKey),
    .iOctUp  (iOctUp),
    .iOctDn  (iOctDn),
    .oRing   (oRing),
    .oFreq   (oFreq),
    .oNoteIdx(oNoteIdx),
    .oOctave (oOctave)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    iReset = 1'b1;
    iKey   = 8'h00;
    iOctUp = 1'b0;
    iOctDn = 1'b0;
    tick(3);
    check("rst_ring", 32'(oRing), 32'd0);
    check("rst_freq", 32'(oFreq), 32'd0);
    check("rst_idx",  32'(oNoteIdx), 32'd0);
    check("rst_oct",  32'(oOctave), 32'd0);
    iReset = 1'b0;
    tick(3);

    // single key: exactly 7 cycles raw -> ring
    iKey = 8'h01;
    tick(6);
    check("k0_ring_early", 32'(oRing), 32'd0);
    tick(1);
    check("k0_ring", 32'(oRing), 32'd1);
    check("k0_freq", 32'(oFreq), 32'd191113);
    check("k0_idx",  32'(oNoteIdx), 32'd0);

    // priority: higher key over held one, release exposes held key
    iKey = 8'h20;
    tick(7);
    check("k5_freq", 32'(oFreq), 32'd113636);
    check("k5_idx",  32'(oNoteIdx), 32'd5);
    iKey = 8'h24;
    tick(6);
    check("k2_freq_early", 32'(oFreq), 32'd113636);
    tick(1);
    check("k2_freq", 32'(oFreq), 32'd151686);
    check("k2_idx",  32'(oNoteIdx), 32'd2);
    check("k2_ring", 32'(oRing), 32'd1);
    iKey = 8'h20;
    tick(7);
    check("k5_back_freq", 32'(oFreq), 32'd113636);
    check("k5_back_ring", 32'(oRing), 32'd1);

    // release: SUSTAIN entered 7 cycles after release, lasts 10 cycles
    iKey = 8'h00;
    tick(16);
    check("sus_ring_last", 32'(oRing), 32'd1);
    tick(1);
    check("sus_ring_off", 32'(oRing), 32'd0);
    check("sus_idx_hold",  32'(oNoteIdx), 32'd5);
    check("sus_freq_hold", 32'(oFreq), 32'd113636);

    // re-press mid-sustain: ring never drops
    iKey = 8'h08;
    tick(7);
    check("k3_ring", 32'(oRing), 32'd1);
    iKey = 8'h00;
    tick(5);
    iKey = 8'h08;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("repress_ring", 32'(oRing), 32'd1);
    end
    check("repress_idx",  32'(oNoteIdx), 32'd3);
    check("repress_freq", 32'(oFreq), 32'd143173);

    // octave up x3 saturates, down x2 reaches -1
    iKey = 8'h01;
    tick(7);
    check("oct_base_freq", 32'(oFreq), 32'd191113);
    for (int p = 0; p < 3; p++) begin
      iOctUp = 1'b1;
      tick(7);
      check("octup_oct",  32'(oOctave), 32'd1);
      check("octup_freq", 32'(oFreq), 32'd95556);
      iOctUp = 1'b0;
      tick(8);
    end
    iOctDn = 1'b1;
    tick(6);
    check("octdn1_early", 32'(oOctave), 32'd1);
    tick(1);
    check("octdn1_oct",  32'(oOctave), 32'd0);
    check("octdn1_freq", 32'(oFreq), 32'd191113);
    iOctDn = 1'b0;
    tick(8);
    iOctDn = 1'b1;
    tick(7);
    check("octdn2_oct",  32'(oOctave), 32'd3);
    check("octdn2_freq", 32'(oFreq), 32'd382226);
    iOctDn = 1'b0;
    tick(8);

    // back to IDLE, then glitches and simultaneous octave buttons
    iKey = 8'h00;
    tick(20);
    check("idle_ring", 32'(oRing), 32'd0);
    iKey = 8'h80;
    tick(3);
    iKey = 8'h00;
    tick(10);
    check("glitch_k7_ring", 32'(oRing), 32'd0);
    check("glitch_k7_idx",  32'(oNoteIdx), 32'd0);
    iOctUp = 1'b1;
    tick(3);
    iOctUp = 1'b0;
    tick(10);
    check("glitch_up_oct",  32'(oOctave), 32'd3);
    check("glitch_up_freq", 32'(oFreq), 32'd382226);
    iOctUp = 1'b1;
    iOctDn = 1'b1;
    tick(10);
    check("both_oct",  32'(oOctave), 32'd3);
    check("both_freq", 32'(oFreq), 32'd382226);
    iOctUp = 1'b0;
    iOctDn = 1'b0;
    tick(10);

    // reset during SUSTAIN, key held across reset replays after 7 cycles
    iKey = 8'h02;
    tick(7);
    check("k1_freq_lo", 32'(oFreq), 32'd340524);
    iKey = 8'h00;
    tick(9);
    check("pre_rst_ring", 32'(oRing), 32'd1);
    iReset = 1'b1;
    iKey   = 8'h02;
    tick(1);
    check("midrst_ring", 32'(oRing), 32'd0);
    check("midrst_freq", 32'(oFreq), 32'd0);
    check("midrst_idx",  32'(oNoteIdx), 32'd0);
    check("midrst_oct",  32'(oOctave), 32'd0);
    iReset = 1'b0;
    tick(6);
    check("replay_early", 32'(oRing), 32'd0);
    tick(1);
    check("replay_ring", 32'(oRing), 32'd1);
    check("replay_freq", 32'(oFreq), 32'd170262);
    check("replay_idx",  32'(oNoteIdx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
